// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : Registered 32-bit MIPS-style integer ALU. It decodes the raw
//             instruction word, selects the operands and operation, and
//             registers the result and status flags on the rising clock edge.
//  Options  : ALU_FLAGS_EN - when defined, the zero, overflow and neg flags
//             are computed and registered. When undefined, the flag outputs
//             are tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_datain,
    input  logic [31:0] gr1,
    input  logic [31:0] gr2,
    output logic [31:0] c,
    output logic        zero,
    output logic        overflow,
    output logic        neg
);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // Decoded fields and debug-visible datapath nets
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] reg_A;
    logic [31:0] reg_B;
    logic [31:0] reg_C;

    logic [4:0]  w_shamt;
    logic [4:0]  w_vshamt;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_ovf_add;
    logic        w_ovf_sub;
    logic        w_ovf;

    logic [31:0] w_c_d;
    logic [31:0] r_c_q;

    assign opcode     = i_datain[31:26];
    assign func       = i_datain[5:0];
    assign w_shamt    = i_datain[10:6];
    assign w_imm_sext = {{16{i_datain[15]}}, i_datain[15:0]};
    assign w_imm_zext = {16'h0000, i_datain[15:0]};

    // Operand selection: rs value is always operand A; operand B is the rt
    // value for R-type and branches, otherwise the extended immediate.
    always_comb begin
        reg_A = gr2;
        reg_B = gr1;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW:
                reg_B = w_imm_sext;
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                reg_B = w_imm_zext;
            default:
                reg_B = gr1;
        endcase
    end

    assign w_vshamt  = reg_A[4:0];
    assign w_sum     = reg_A + reg_B;
    assign w_diff    = reg_A - reg_B;
    // Signed overflow: same-sign add or opposite-sign subtract whose result
    // sign disagrees with operand A.
    assign w_ovf_add = (reg_A[31] == reg_B[31]) && (w_sum[31]  != reg_A[31]);
    assign w_ovf_sub = (reg_A[31] != reg_B[31]) && (w_diff[31] != reg_A[31]);

    // Operation select: undefined encodings yield a zero result, no overflow.
    always_comb begin
        reg_C = 32'h0000_0000;
        w_ovf = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_SLL:  reg_C = reg_B << w_shamt;
                    FN_SRL:  reg_C = reg_B >> w_shamt;
                    FN_SRA:  reg_C = $unsigned($signed(reg_B) >>> w_shamt);
                    FN_SLLV: reg_C = reg_B << w_vshamt;
                    FN_SRLV: reg_C = reg_B >> w_vshamt;
                    FN_SRAV: reg_C = $unsigned($signed(reg_B) >>> w_vshamt);
                    FN_ADD: begin
                        reg_C = w_sum;
                        w_ovf = w_ovf_add;
                    end
                    FN_ADDU: reg_C = w_sum;
                    FN_SUB: begin
                        reg_C = w_diff;
                        w_ovf = w_ovf_sub;
                    end
                    FN_SUBU: reg_C = w_diff;
                    FN_AND:  reg_C = reg_A & reg_B;
                    FN_OR:   reg_C = reg_A | reg_B;
                    FN_XOR:  reg_C = reg_A ^ reg_B;
                    FN_NOR:  reg_C = ~(reg_A | reg_B);
                    FN_SLT:  reg_C = {31'd0, ($signed(reg_A) < $signed(reg_B))};
                    FN_SLTU: reg_C = {31'd0, (reg_A < reg_B)};
                    default: reg_C = 32'h0000_0000;
                endcase
            end
            OP_ADDI: begin
                reg_C = w_sum;
                w_ovf = w_ovf_add;
            end
            OP_ADDIU, OP_LW, OP_SW: reg_C = w_sum;
            OP_SLTI:  reg_C = {31'd0, ($signed(reg_A) < $signed(reg_B))};
            OP_SLTIU: reg_C = {31'd0, (reg_A < reg_B)};
            OP_ANDI:  reg_C = reg_A & reg_B;
            OP_ORI:   reg_C = reg_A | reg_B;
            OP_XORI:  reg_C = reg_A ^ reg_B;
            OP_LUI:   reg_C = {i_datain[15:0], 16'h0000};
            OP_BEQ, OP_BNE: reg_C = w_diff;
            default:  reg_C = 32'h0000_0000;
        endcase
    end

    // Next-state value of the result register
    always_comb begin
        w_c_d = reg_C;
    end

    // Result register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_q <= 32'h0000_0000;
        end else begin
            r_c_q <= w_c_d;
        end
    end

    assign c = r_c_q;

`ifdef ALU_FLAGS_EN
    logic w_zero_d;
    logic w_overflow_d;
    logic w_neg_d;
    logic r_zero_q;
    logic r_overflow_q;
    logic r_neg_q;
    logic w_unused;

    // Flag next-state values derived from the combinational result
    always_comb begin
        w_zero_d     = (reg_C == 32'h0000_0000);
        w_overflow_d = w_ovf;
        w_neg_d      = reg_C[31];
    end

    // Flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero_q     <= 1'b0;
            r_overflow_q <= 1'b0;
            r_neg_q      <= 1'b0;
        end else begin
            r_zero_q     <= w_zero_d;
            r_overflow_q <= w_overflow_d;
            r_neg_q      <= w_neg_d;
        end
    end

    assign zero     = r_zero_q;
    assign overflow = r_overflow_q;
    assign neg      = r_neg_q;
    // Register-address fields are decoded upstream, not here.
    assign w_unused = ^i_datain[25:16];
`else
    logic w_unused;

    assign zero     = 1'b0;
    assign overflow = 1'b0;
    assign neg      = 1'b0;
    // Register-address fields and the overflow term have no sink without flags.
    assign w_unused = ^{i_datain[25:16], w_ovf};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu
//  Purpose  : Scoreboard bench for alu. The driver pushes the expected
//             registered response per issued instruction; a monitor pops and
//             compares one cycle later.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu;

`ifdef ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [31:0] c;
        logic [2:0]  f;   // {zero, overflow, neg}
        string       nm;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] i_datain;
    logic [31:0] gr1;
    logic [31:0] gr2;
    logic [31:0] c;
    logic        zero;
    logic        overflow;
    logic        neg;

    exp_t q[$];
    int   checks;
    int   failures;
    bit   issued;
    bit   vld_s;
    exp_t e;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .i_datain (i_datain),
        .gr1      (gr1),
        .gr2      (gr2),
        .c        (c),
        .zero     (zero),
        .overflow (overflow),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one instruction for one cycle and record its expected response.
    task automatic issue(input string nm, input logic r, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ec, input logic ez, input logic eo,
                         input logic en);
        exp_t x;
        @(negedge clk);
        rst      = r;
        i_datain = ins;
        gr2      = a;
        gr1      = b;
        x.c  = ec;
        x.f  = {ez & FLAGS, eo & FLAGS, en & FLAGS};
        x.nm = nm;
        q.push_back(x);
        issued = 1'b1;
    endtask

    // Monitor: every edge that captured an issued instruction is checked 1 time unit later.
    always @(posedge clk) begin
        vld_s = issued;
        #1;
        if (vld_s) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: output with no expected entry");
            end else begin
                e = q.pop_front();
                checks++;
                if (c !== e.c) begin
                    failures++;
                    $display("FAIL %s c: got %08h expected %08h", e.nm, c, e.c);
                end
                checks++;
                if ({zero, overflow, neg} !== e.f) begin
                    failures++;
                    $display("FAIL %s flags(z,o,n): got %03b expected %03b",
                             e.nm, {zero, overflow, neg}, e.f);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        issued   = 1'b0;
        rst      = 1'b1;
        i_datain = 32'h0;
        gr1      = 32'h0;
        gr2      = 32'h0;
        @(negedge clk);
        @(negedge clk);
        //     name          rst  instr         gr2           gr1           c             z     o     n
        issue("reset_state", 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        issue("sll1",        1'b0, 32'h00011040, 32'h00000000, 32'hDDDDDDDD, 32'hBBBBBBBA, 1'b0, 1'b0, 1'b1);
        issue("sll2",        1'b0, 32'h00011080, 32'h00000000, 32'hDDDDDDDD, 32'h77777774, 1'b0, 1'b0, 1'b0);
        issue("sll4",        1'b0, 32'h00011100, 32'h00000000, 32'h40404040, 32'h04040400, 1'b0, 1'b0, 1'b0);
        issue("add_ovf",     1'b0, 32'h00221820, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1);
        issue("addu_noovf",  1'b0, 32'h00221821, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1);
        issue("sub_ovf",     1'b0, 32'h00221822, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        issue("sra4",        1'b0, 32'h00011103, 32'h00000000, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b1);
        issue("srl31",       1'b0, 32'h000117C2, 32'h00000000, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0);
        issue("sll0",        1'b0, 32'h00011000, 32'h00000000, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0);
        issue("srav4",       1'b0, 32'h00221807, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b1);
        issue("sltu",        1'b0, 32'h0022182B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0);
        issue("slt",         1'b0, 32'h0022182A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
        issue("nor",         1'b0, 32'h00221827, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        issue("lui",         1'b0, 32'h3C001234, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12340000, 1'b0, 1'b0, 1'b0);
        issue("addi",        1'b0, 32'h2000FFFF, 32'h00000005, 32'h00000000, 32'h00000004, 1'b0, 1'b0, 1'b0);
        issue("andi",        1'b0, 32'h300080F0, 32'hFFFFFFFF, 32'h00000000, 32'h000080F0, 1'b0, 1'b0, 1'b0);
        issue("beq_eq",      1'b0, 32'h10220003, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0);
        issue("lw_addr",     1'b0, 32'h8C22FFFC, 32'h00001000, 32'h00000000, 32'h00000FFC, 1'b0, 1'b0, 1'b0);
        issue("rst_over_add",1'b1, 32'h00221820, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b0);
        issue("add_after_rst",1'b0,32'h00221820, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0);
        issue("undef_op",    1'b0, 32'hFC000000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0);
        issue("undef_func",  1'b0, 32'h0022183F, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0);
        // Mid-cycle input change must not affect the captured result.
        issue("midcycle",    1'b0, 32'h00221821, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        gr1 = 32'hFFFFFFFF;
        @(negedge clk);
        issued = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
